// File: rtl/adc_spi_capture.sv
// Serial front end for a 12-bit SPI ADC (ADC121S101-style 16-SCLK frame).
// Define ADC_LEADING_ZERO_CHECK_EN to reject frames whose leading bits are not zero.
module adc_spi_capture #(
    parameter int N_ADC         = 12,
    parameter int FRAME         = 16,
    parameter int SCLK_HALF     = 5,
    parameter int SAMPLE_PERIOD = 2268,
    parameter int QUIET         = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sdata,
    output logic             cs_n,
    output logic             sclk,
    output logic [N_ADC-1:0] data_ADC,
    output logic             dato_listo,
    output logic             busy,
    output logic             frame_err
);

    localparam int SMP_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DIV_W   = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int BIT_W   = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int QUIET_W = (QUIET > 1) ? $clog2(QUIET) : 1;

    // Leading bits only need to be kept when they are going to be checked.
`ifdef ADC_LEADING_ZERO_CHECK_EN
    localparam int SHIFT_W = FRAME;
`else
    localparam int SHIFT_W = N_ADC;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_DONE  = 2'd2,
        S_QUIET = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [SMP_W-1:0]   smp_reg, smp_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [BIT_W-1:0]   bit_reg, bit_next;
    logic [QUIET_W-1:0] quiet_reg, quiet_next;
    logic [SHIFT_W-1:0] shift_reg, shift_next;
    logic [N_ADC-1:0]   data_reg, data_next;
    logic               sclk_reg, sclk_next;
    logic               listo_reg, listo_next;
    logic               err_reg, err_next;
    logic               tick;

    // Free-running sample-rate counter; the wrap cycle starts a conversion.
    assign tick = enable && (smp_reg == SMP_W'(SAMPLE_PERIOD - 1));

    always_comb begin
        smp_next = smp_reg;
        if (!enable || tick) begin
            smp_next = '0;
        end else begin
            smp_next = smp_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        quiet_next = quiet_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        sclk_next  = sclk_reg;
        listo_next = 1'b0;
        err_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                sclk_next = 1'b1;
                div_next  = '0;
                bit_next  = '0;
                if (tick) begin
                    state_next = S_CONV;
                end
            end

            S_CONV: begin
                if (div_reg == DIV_W'(SCLK_HALF - 1)) begin
                    div_next  = '0;
                    sclk_next = ~sclk_reg;
                    // sclk low now means this divider wrap makes a rising edge.
                    if (!sclk_reg) begin
                        shift_next = {shift_reg[SHIFT_W-2:0], sdata};
                        bit_next   = bit_reg + 1'b1;
                        if (bit_reg == BIT_W'(FRAME - 1)) begin
                            state_next = S_DONE;
                        end
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end

            S_DONE: begin
`ifdef ADC_LEADING_ZERO_CHECK_EN
                if (shift_reg[SHIFT_W-1:N_ADC] != '0) begin
                    err_next = 1'b1;
                end else begin
                    data_next  = shift_reg[N_ADC-1:0];
                    listo_next = 1'b1;
                end
`else
                data_next  = shift_reg[N_ADC-1:0];
                listo_next = 1'b1;
`endif
                quiet_next = QUIET_W'(QUIET - 1);
                state_next = S_QUIET;
            end

            S_QUIET: begin
                if (quiet_reg == '0) begin
                    state_next = S_IDLE;
                end else begin
                    quiet_next = quiet_reg - 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            smp_reg   <= '0;
            div_reg   <= '0;
            bit_reg   <= '0;
            quiet_reg <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            sclk_reg  <= 1'b1;
            listo_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            smp_reg   <= smp_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            quiet_reg <= quiet_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            sclk_reg  <= sclk_next;
            listo_reg <= listo_next;
            err_reg   <= err_next;
        end
    end

    // cs_n decodes straight from the state so an async reset raises it at once.
    assign cs_n       = (state_reg != S_CONV);
    assign busy       = (state_reg == S_CONV);
    assign sclk       = sclk_reg;
    assign data_ADC   = data_reg;
    assign dato_listo = listo_reg;
    assign frame_err  = err_reg;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture with a behavioural ADC121S101-style serial model.
// Expectations for the leading-zero frame follow ADC_LEADING_ZERO_CHECK_EN.
module tb_adc_spi_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        sdata = 1'b0;
    logic        cs_n;
    logic        sclk;
    logic [11:0] data_ADC;
    logic        dato_listo;
    logic        busy;
    logic        frame_err;

    adc_spi_capture #(
        .N_ADC         (12),
        .FRAME         (16),
        .SCLK_HALF     (2),
        .SAMPLE_PERIOD (100),
        .QUIET         (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .sdata      (sdata),
        .cs_n       (cs_n),
        .sclk       (sclk),
        .data_ADC   (data_ADC),
        .dato_listo (dato_listo),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // ADC model: each frame takes the next queued word, shifted out MSB first on sclk falls.
    logic [15:0] word_q[$];
    logic [15:0] cur_word = 16'h0000;
    int          bit_idx  = -1;

    always @(negedge cs_n) begin
        if (word_q.size() > 0) cur_word = word_q.pop_front();
        bit_idx = 15;
    end

    always @(negedge sclk) begin
        if (!cs_n && bit_idx >= 0) begin
            sdata   = cur_word[bit_idx];
            bit_idx = bit_idx - 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Observation state, sampled on the falling clk edge.
    int cyc = 0;
    int base = 0;
    int rise_run = 0;
    int cs_low_run = 0;
    int cs_high_run = 0;
    int cs_low_total = 0;
    int sclk_low_total = 0;
    logic cs_prev = 1'b1;
    logic sclk_prev = 1'b1;
    int frame_len[$];
    int frame_rises[$];
    int gaps[$];
    int strobe_cyc[$];
    int strobe_data[$];
    int err_cyc[$];

    task automatic clear_stats();
        base = cyc;
        rise_run = 0;
        cs_low_run = 0;
        cs_high_run = 0;
        cs_low_total = 0;
        sclk_low_total = 0;
        frame_len.delete();
        frame_rises.delete();
        gaps.delete();
        strobe_cyc.delete();
        strobe_data.delete();
        err_cyc.delete();
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (sclk === 1'b1 && sclk_prev === 1'b0) rise_run++;
        if (sclk === 1'b0) sclk_low_total++;
        if (cs_n === 1'b0) begin
            cs_low_run++;
            cs_low_total++;
        end
        if (cs_n === 1'b1 && cs_prev === 1'b0) begin
            frame_len.push_back(cs_low_run);
            frame_rises.push_back(rise_run);
            cs_low_run = 0;
            rise_run = 0;
        end
        if (cs_n === 1'b0 && cs_prev === 1'b1) begin
            if (frame_len.size() > 0) gaps.push_back(cs_high_run);
            cs_high_run = 0;
        end
        if (cs_n === 1'b1) cs_high_run++;
        if (dato_listo === 1'b1) begin
            strobe_cyc.push_back(cyc - base);
            strobe_data.push_back(int'(data_ADC));
            $display("strobe t=%0d data_ADC=0x%03h", cyc - base, data_ADC);
        end
        if (frame_err === 1'b1) begin
            err_cyc.push_back(cyc - base);
            $display("frame_err pulse t=%0d data_ADC=0x%03h", cyc - base, data_ADC);
        end
        cs_prev = cs_n;
        sclk_prev = sclk;
    endtask

    initial begin
        int guard;
        int min_gap;

        // Reset and idle
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) step();
        check_val("rst_cs_n", cs_n, 1'b1);
        check_val("rst_sclk", sclk, 1'b1);
        check_val("rst_data", data_ADC, 12'h000);
        check_val("rst_listo", dato_listo, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_err", frame_err, 1'b0);
        reset_n = 1'b1;
        clear_stats();
        repeat (300) step();
        check_val("idle_cs_low", cs_low_total, 0);
        check_val("idle_sclk_low", sclk_low_total, 0);
        check_val("idle_strobes", strobe_cyc.size(), 0);
        check_val("idle_data", data_ADC, 12'h000);

        // Single frame, then continuous frames, then enable dropped mid-frame
        word_q.push_back(16'h0ABC);
        word_q.push_back(16'h0000);
        word_q.push_back(16'h0FFF);
        word_q.push_back(16'h0800);
        word_q.push_back(16'h0123);
        enable = 1'b1;
        clear_stats();
        repeat (510) step();
        check_val("drop_busy_mid", busy, 1'b1);
        enable = 1'b0;
        repeat (60) step();

        check_val("single_cs_low_len", qget(frame_len, 0), 64);
        check_val("single_rises", qget(frame_rises, 0), 16);
        check_val("single_strobe_t", qget(strobe_cyc, 0), 165);
        check_val("single_data", qget(strobe_data, 0), 12'hABC);
        check_val("cont_strobe_count", strobe_cyc.size(), 5);
        check_val("cont_gap1", qget(strobe_cyc, 1) - qget(strobe_cyc, 0), 100);
        check_val("cont_gap2", qget(strobe_cyc, 2) - qget(strobe_cyc, 1), 100);
        check_val("cont_gap3", qget(strobe_cyc, 3) - qget(strobe_cyc, 2), 100);
        check_val("cont_data_000", qget(strobe_data, 1), 12'h000);
        check_val("cont_data_fff", qget(strobe_data, 2), 12'hFFF);
        check_val("cont_data_800", qget(strobe_data, 3), 12'h800);
        check_val("cont_frame_len3", qget(frame_len, 3), 64);
        check_val("cont_rises3", qget(frame_rises, 3), 16);
        min_gap = 1000;
        foreach (gaps[i]) if (gaps[i] < min_gap) min_gap = gaps[i];
        check_val("cont_gap_count", gaps.size(), 4);
        check_val("cont_quiet_ge4", (min_gap >= 4), 1'b1);
        check_val("drop_strobe_t", qget(strobe_cyc, 4), 565);
        check_val("drop_data", qget(strobe_data, 4), 12'h123);
        check_val("drop_frame_len", qget(frame_len, 4), 64);
        check_val("no_err_normal", err_cyc.size(), 0);

        clear_stats();
        repeat (500) step();
        check_val("drop_cs_low_after", cs_low_total, 0);
        check_val("drop_sclk_low_after", sclk_low_total, 0);
        check_val("drop_strobes_after", strobe_cyc.size(), 0);
        check_val("drop_data_hold", data_ADC, 12'h123);

        // Reset at the 7th rising sclk edge of a frame
        word_q.push_back(16'h0FFF);
        word_q.push_back(16'h05A5);
        word_q.push_back(16'h4005);
        enable = 1'b1;
        clear_stats();
        guard = 0;
        while (!(rise_run == 7 && cs_n === 1'b0) && guard < 300) begin
            step();
            guard++;
        end
        check_val("rstmid_reached_rise7", (guard < 300), 1'b1);
        check_val("rstmid_rise7_t", cyc - base, 128);
        reset_n = 1'b0;
        #1;
        check_val("rstmid_cs_n", cs_n, 1'b1);
        check_val("rstmid_sclk", sclk, 1'b1);
        check_val("rstmid_data", data_ADC, 12'h000);
        check_val("rstmid_busy", busy, 1'b0);
        repeat (3) step();
        check_val("rstmid_no_strobe", strobe_cyc.size(), 0);
        reset_n = 1'b1;
        clear_stats();
        repeat (170) step();
        check_val("rstmid_next_strobe_t", qget(strobe_cyc, 0), 165);
        check_val("rstmid_next_data", qget(strobe_data, 0), 12'h5A5);
        check_val("rstmid_next_rises", qget(frame_rises, 0), 16);

        // Frame with a non-zero leading bit
        clear_stats();
        base = base - 170;
        repeat (100) step();
`ifdef ADC_LEADING_ZERO_CHECK_EN
        check_val("lz_err_count", err_cyc.size(), 1);
        check_val("lz_err_t", qget(err_cyc, 0), 265);
        check_val("lz_no_strobe", strobe_cyc.size(), 0);
        check_val("lz_data_hold", data_ADC, 12'h5A5);
`else
        check_val("lz_strobe_count", strobe_cyc.size(), 1);
        check_val("lz_strobe_t", qget(strobe_cyc, 0), 265);
        check_val("lz_data", qget(strobe_data, 0), 12'h005);
        check_val("lz_no_err", err_cyc.size(), 0);
`endif
        enable = 1'b0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_capture.md
Name: adc_spi_capture

Overview:
- Serial front end for the 12-bit SPI ADC (ADC121S101-style: 16-SCLK frame, 4 leading zeros, then 12 data bits MSB first).
- Generates cs_n and sclk at a fixed audio sample rate and deserialises SDATA.
- Presents a parallel unsigned code plus a one-cycle valid strobe.
- data_ADC feeds the ADC concatenation / offset-removal stage directly upstream of the filters.

Parameters:
- N_ADC, 12, ADC code width.
- FRAME, 16, SCLK cycles per conversion (FRAME-N_ADC leading zeros).
- SCLK_HALF, 5, clk cycles per SCLK half-period (100 MHz clk -> 10 MHz SCLK).
- SAMPLE_PERIOD, 2268, clk cycles between conversion starts (100 MHz -> ~44.1 kHz).
- QUIET, 4, minimum clk cycles cs_n stays high between frames.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  1 = free-running conversions allowed
- sdata  input  1  ADC serial data
- cs_n  output  1  ADC chip select, active low
- sclk  output  1  ADC serial clock, idles high
- data_ADC  output  N_ADC  last captured code, unsigned
- dato_listo  output  1  one-cycle pulse, data_ADC updated this cycle
- busy  output  1  high while frame in progress (cs_n low)
- frame_err  output  1  see Optional Feature

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n).
  - While reset_n=0 and on release: cs_n=1, sclk=1, data_ADC=0, dato_listo=0, busy=0, frame_err=0.
  - State, sample counter, bit counter, divider and shift register all cleared.
- Reset asserted mid-frame aborts the frame immediately: cs_n and sclk go high asynchronously, no dato_listo.
- Sample counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps while enable=1; held at 0 while enable=0.
  - The wrap cycle is the sample tick.
  - First tick occurs SAMPLE_PERIOD-1 cycles after enable rises.
- FSM:
  - IDLE: cs_n=1, sclk=1. On tick -> CONV; cs_n falls next cycle. Bit counter=0, divider=0.
  - CONV: sclk toggles every SCLK_HALF clk cycles, starting with a falling edge SCLK_HALF cycles after cs_n falls.
    - sdata is sampled into the shift register (shift left, LSB in) on the clk cycle the divider creates each sclk rising edge.
    - After the FRAME-th rising edge -> DONE.
  - DONE (1 cycle):
    - cs_n=1, busy=0.
    - data_ADC <= shift[N_ADC-1:0]; dato_listo=1.
    - Quiet counter loaded -> QUIETST.
  - QUIETST: cs_n held high for QUIET cycles, then -> IDLE.
- Frame timing:
  - Frame length = 2*SCLK_HALF*FRAME clk cycles from cs_n fall to the last rising edge.
  - Tick-to-dato_listo latency = 2*SCLK_HALF*FRAME + 2 cycles.
- Overrun: a tick arriving when not in IDLE is dropped, with no restart and no corruption. The legal configuration requires SAMPLE_PERIOD >= 2*SCLK_HALF*FRAME + QUIET + 3.
- enable falling mid-frame: current frame completes normally, including dato_listo; no new start.
- data_ADC holds its value between strobes. Downstream samples it only on dato_listo.

Optional Feature:
- Macro: ADC_LEADING_ZERO_CHECK_EN.
- Defined: in DONE, the top FRAME-N_ADC bits of the shift register are checked.
  - If any bit is 1: data_ADC is not updated, dato_listo stays 0, frame_err pulses 1 for one cycle.
  - Otherwise normal completion.
- Undefined: leading bits ignored, frame_err tied 0, every frame updates data_ADC.

Test Plan (bench parameters SCLK_HALF=2, SAMPLE_PERIOD=100, QUIET=4):
- Reset/idle: hold reset_n=0, then release with enable=0 for 300 cycles -> cs_n=1, sclk=1, data_ADC=0, no dato_listo.
- Single frame: enable=1, ADC model drives 0000_1010_1011_1100 -> cs_n low exactly 64 cycles, 16 sclk rising edges, data_ADC=12'hABC with dato_listo one cycle at tick+66.
- Continuous: model returns 12'h000, 12'hFFF, 12'h800 on successive frames -> three strobes spaced exactly 100 cycles, data_ADC matches in order, cs_n high >=4 cycles between frames.
- Reset mid-frame: assert reset_n=0 at the 7th sclk rising edge -> cs_n=1 and sclk=1 within the same cycle, data_ADC=0. After release, the next frame captures correctly.
- Enable drop: deassert enable during a frame carrying 12'h123 -> that frame strobes data_ADC=12'h123, then no further cs_n activity for 500 cycles.
- Leading-zero check (macro defined): model drives 0100_0000_0000_0101 -> frame_err one-cycle pulse, no dato_listo, data_ADC unchanged. With the macro undefined, same stimulus -> data_ADC=12'h005, dato_listo pulses.
